blink_arbiter: RTL
==================

Name: blink_arbiter

Overview:
Shares the single status LED between N_REQ requesters. Each requester asks for a blink burst, given as a blink count and a per-phase duration in ms. Requests are served round-robin, one burst at a time, and each burst is followed by a fixed dark gap so consecutive bursts stay visually distinct. The block sits between status-generating logic (error, heartbeat, activity sources) and the board LED pin, and owns the ms timebase.

Parameters:
CLK_FREQ, 100_000_000, clk frequency in Hz; must be a multiple of 1000.
N_REQ, 4, number of requesters (2..8).
RATE_W, 16, width of each rate_ms field.
CNT_W, 8, width of each blinks field.
GAP_MS, 200, LED-off gap in ms after every burst (abort or completion).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high.
req  in  N_REQ  level request, held high until done or withdrawn.
rate_ms  in  N_REQ*RATE_W  packed per-requester ON and OFF phase duration in ms.
blinks  in  N_REQ*CNT_W  packed per-requester blink count.
grant  out  N_REQ  one-hot, high while the requester is being served.
done  out  N_REQ  one-cycle pulse when the requester's burst completes.
busy  out  1  high in any state other than IDLE.
led  out  1  LED drive, high = on.

Behaviour:
- Decided: reset is asynchronous and active-high; clock is clk.
- Reset values: led=0, grant=0, done=0, busy=0, state=IDLE, rr_ptr=0, all counters=0. Reset mid-burst takes effect immediately; there is no done pulse and no gap.
- Timebase:
  - MS_DIV = CLK_FREQ/1000.
  - Prescaler counts 0..MS_DIV-1 and emits ms_tick on MS_DIV-1.
  - Prescaler restarts at 0 on the entry cycle of every ON, OFF and GAP phase, so each phase lasts exactly duration*MS_DIV cycles.
- States: IDLE, ON, OFF, GAP (registered FSM).
- IDLE:
  - led=0, grant=0.
  - If req!=0, pick the first set bit searching from rr_ptr upward, with wrap-around.
  - Latch r=max(rate_ms[i],1), so 0 is treated as 1, and n=blinks[i]; set rr_ptr=i+1 mod N_REQ.
  - If n=0: pulse done[i] next cycle, no grant, go to GAP.
  - Else: next cycle grant[i]=1, led=1, state=ON, remaining=n. Latency from req rising in IDLE to led high is 1 cycle.
  - Inputs are sampled only at latch; later changes to rate_ms or blinks are ignored.
- ON: led=1 for r ms, then go to OFF.
- OFF: led=0 for r ms. Then remaining decrements:
  - If it reaches 0: done[i] pulses for one cycle together with the transition to GAP, and grant drops in that same cycle.
  - Otherwise go to ON.
- GAP: led=0, grant=0 for GAP_MS ms, then go to IDLE. Requests are not arbitrated during GAP.
- Abort: if req[i] falls while in ON or OFF, go to GAP next cycle with led=0, grant=0 and no done pulse.
- A request that is high in GAP or IDLE is served only after the current gap; no request is dropped.
- Simultaneous events: completion on the same cycle as req[i] falling counts as completion, so done pulses.
- Width rules:
  - Phase counter width is RATE_W; GAP_MS must fit in RATE_W.
  - Prescaler width is $clog2(MS_DIV).
  - Burst length is n*2*r ms; there is no overflow handling beyond the counter widths.

Decomposition:
- Package blink_pkg: state enum type, MS_PER_SEC=1000, function ms_div(CLK_FREQ).
- Sub-module ms_tick_gen (params CLK_FREQ; ports clk, reset, restart, tick): synchronous restart, asynchronous reset.
- Round-robin pick is a combinational function inside blink_arbiter.

Test Plan:
(All with CLK_FREQ=10_000, so MS_DIV=10, and GAP_MS=3.)
- Single burst: req[0]=1, rate=2, blinks=3 -> led high 20 cycles and low 20 cycles, three times. done[0] pulses once at cycle 120 after grant. led low 30 cycles. Then back to IDLE with busy=0.
- Round-robin: req=4'b1111 held, each rate=1, blinks=1 -> grant order 0,1,2,3,0. Each grant lasts 20 cycles with a 30-cycle gap between grants.
- Zero counts: blinks[2]=0 -> done[2] pulses 1 cycle after pickup, grant[2] never rises, led stays 0, 30-cycle gap follows. Separately, rate=0, blinks=1 -> 10-cycle ON.
- Abort: req[1] dropped 5 cycles into the second ON -> led=0 and grant=0 next cycle, no done[1], 30-cycle gap, then the next requester is served.
- Reset mid-ON: assert reset asynchronously -> led, grant, busy go 0 without waiting for a clock edge. After release with req[0] still high, led rises 1 cycle after the first clock edge and the burst restarts from full count.
- Mid-burst input change: change rate_ms[0] from 2 to 5 during a burst -> phase lengths stay 20 cycles until done.

Source files
------------

// File: rtl/blink_pkg.sv
// Purpose: shared types and helpers for the status-LED blink arbiter.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: state_e (arbiter FSM states), MS_PER_SEC, ms_div() clock-to-ms divider.
package blink_pkg;

  localparam int MS_PER_SEC = 1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Clock cycles per millisecond; CLK_FREQ is expected to be a multiple of 1000.
  function automatic int ms_div(input int clk_freq);
    return clk_freq / MS_PER_SEC;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Purpose: millisecond prescaler; tick is high for one cycle every CLK_FREQ/1000 cycles.
// Latency: restart sampled on an edge gives count 0 in the following cycle; first tick MS_DIV-1 cycles later.
// Backpressure: none, free-running apart from restart.
// Ports: clk, reset (async, active-high), restart (sync clear to 0), tick (high while count == MS_DIV-1).
module ms_tick_gen
  import blink_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int MS_DIV = ms_div(CLK_FREQ);
  // Guard the degenerate MS_DIV == 1 case so the counter never has zero width.
  localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/blink_arbiter.sv
// Purpose: round-robin share of one status LED between N_REQ blink-burst requesters, with a dark gap after each burst.
// Latency: req seen in IDLE -> grant/led high 1 cycle later; each ON/OFF/GAP phase lasts duration*MS_DIV cycles.
// Backpressure: level requests wait (never dropped) while another burst or a gap is in progress; dropping req aborts.
// Ports: clk, reset (async, active-high); req[N_REQ] level requests; rate_ms[N_REQ*RATE_W] per-requester
//        phase length in ms; blinks[N_REQ*CNT_W] per-requester blink count; grant[N_REQ] one-hot while served;
//        done[N_REQ] one-cycle completion pulse; busy (not IDLE); led (high = on).
module blink_arbiter
  import blink_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int N_REQ    = 4,
  parameter int RATE_W   = 16,
  parameter int CNT_W    = 8,
  parameter int GAP_MS   = 200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*RATE_W-1:0]   rate_ms,
  input  logic [N_REQ*CNT_W-1:0]    blinks,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      busy,
  output logic                      led
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [RATE_W-1:0] GAP_LEN  = RATE_W'(GAP_MS);

  // First set request at or above ptr, wrapping past the top index.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] cand;
    logic             found;
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
    return sel;
  endfunction

  state_e            state_q,  state_d;
  logic [PTR_W-1:0]  idx_q,    idx_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [RATE_W-1:0] rate_q,   rate_d;
  logic [CNT_W-1:0]  rem_q,    rem_d;
  logic [RATE_W-1:0] phase_q,  phase_d;
  logic [N_REQ-1:0]  done_q,   done_d;

  logic              ms_tick;
  logic              restart;
  logic              phase_end;
  logic [RATE_W-1:0] phase_len;
  logic [PTR_W-1:0]  pick_idx;
  logic [RATE_W-1:0] pick_rate;
  logic [CNT_W-1:0]  pick_blk;
  logic              req_cur;
  logic              last_blink;

  logic [RATE_W-1:0] rate_arr [N_REQ];
  logic [CNT_W-1:0]  blk_arr  [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rate_arr[i] = rate_ms[i*RATE_W +: RATE_W];
      blk_arr[i]  = blinks[i*CNT_W +: CNT_W];
    end
  end

  ms_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_ms_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (ms_tick)
  );

  assign pick_idx  = rr_pick(req, rr_ptr_q);
  assign pick_rate = rate_arr[pick_idx];
  assign pick_blk  = blk_arr[pick_idx];
  assign req_cur   = req[idx_q];

  // ON/OFF use the latched rate; GAP uses the fixed gap length. Both are >= 1 ms.
  assign phase_len  = (state_q == ST_GAP) ? GAP_LEN : rate_q;
  assign phase_end  = ms_tick && (phase_q == (phase_len - 1'b1));
  assign last_blink = (rem_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    rate_d   = rate_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    done_d   = '0;
    restart  = 1'b0;

    if (ms_tick) begin
      phase_d = phase_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          idx_d    = pick_idx;
          rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          rate_d   = (pick_rate == '0) ? RATE_W'(1) : pick_rate;
          rem_d    = pick_blk;
          if (pick_blk == '0) begin
            // Nothing to show: acknowledge straight away, still pay the gap.
            done_d[pick_idx] = 1'b1;
            state_d          = ST_GAP;
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (!req_cur) begin
          state_d = ST_GAP;
        end else if (phase_end) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        // Completion wins over a request dropped on the same cycle.
        if (phase_end && last_blink) begin
          rem_d         = rem_q - 1'b1;
          done_d[idx_q] = 1'b1;
          state_d       = ST_GAP;
        end else if (!req_cur) begin
          state_d = ST_GAP;
        end else if (phase_end) begin
          rem_d   = rem_q - 1'b1;
          state_d = ST_ON;
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every timed phase starts with a fresh ms prescaler and phase count.
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      restart = 1'b1;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      rate_q   <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      rate_q   <= rate_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
    end
  end

  // Outputs decode registered state only, so async reset clears them at once.
  always_comb begin
    grant = '0;
    if ((state_q == ST_ON) || (state_q == ST_OFF)) begin
      grant[idx_q] = 1'b1;
    end
  end

  assign led  = (state_q == ST_ON);
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule
